ysyx_22040632_mulctl: RTL and testbench

YSYX_22040632_MULCTL -- requirements
Module: ysyx_22040632_mulctl

---
 rtl/ysyx_22040632_mulctl_if.sv | 30 +++
 rtl/ysyx_22040632_mulctl.sv | 127 ++++++++++++
 tb/tb_ysyx_22040632_mulctl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_mulctl_if.sv
// Operand/result bus between the multiply control block and the multiply unit.
// The unit must present result_hi/result_lo for operands held stable for LATENCY cycles.
interface ysyx_22040632_mulif;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport cpu (
    output mulw, mul_signed, multiplicand, multiplier,
    input  result_hi, result_lo
  );

  modport unit (
    input  mulw, mul_signed, multiplicand, multiplier,
    output result_hi, result_lo
  );

  modport master (
    output mulw, mul_signed, multiplicand, multiplier,
    input  result_hi, result_lo
  );

  modport slave (
    input  mulw, mul_signed, multiplicand, multiplier,
    output result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_22040632_mulctl.sv
// Multiply control: captures one request, holds operands for a fixed-latency multiply unit,
// then presents the selected rd value until the consumer accepts it.
module ysyx_22040632_mulctl #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [4:0]  tag_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_tag,
  ysyx_22040632_mulif.cpu mul
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [63:0] src1_q;
  logic [63:0] src2_q;
  logic [1:0]  op_q;
  logic        word_q;
  logic [4:0]  tag_q;
  logic        mulw_q;
  logic [1:0]  sign_q;
  logic [1:0]  sign_dec;
  logic [63:0] sel_result;

  assign in_ready          = (state == IDLE);
  assign mul.multiplicand  = src1_q;
  assign mul.multiplier    = src2_q;
  assign mul.mulw          = mulw_q;
  assign mul.mul_signed    = sign_q;

  // Bit 1 is rs1 signedness, bit 0 is rs2 signedness; MULW is always signed x signed.
  always_comb begin
    sign_dec = 2'b11;
    if (!word) begin
      case (op)
        2'b10:   sign_dec = 2'b10;
        2'b11:   sign_dec = 2'b00;
        default: sign_dec = 2'b11;
      endcase
    end
  end

  always_comb begin
    sel_result = mul.result_hi;
    if (word_q) begin
      sel_result = {{32{mul.result_lo[31]}}, mul.result_lo[31:0]};
    end else if (op_q == 2'b00) begin
      sel_result = mul.result_lo;
    end
  end

  // Reset beats flush, and flush beats everything else, including a pending handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      out_valid  <= 1'b0;
      out_result <= 64'd0;
      out_tag    <= 5'd0;
      src1_q     <= 64'd0;
      src2_q     <= 64'd0;
      op_q       <= 2'd0;
      word_q     <= 1'b0;
      tag_q      <= 5'd0;
      mulw_q     <= 1'b0;
      sign_q     <= 2'd0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= WAIT;
            count  <= LAT;
            src1_q <= src1;
            src2_q <= src2;
            op_q   <= op;
            word_q <= word;
            tag_q  <= tag_in;
            mulw_q <= word;
            sign_q <= sign_dec;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= sel_result;
            out_tag    <= tag_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_mulctl.sv
// Bench for the multiply control block: instance 0 runs with LATENCY=3, instance 1 with LATENCY=1,
// each paired with a behavioural multiply unit that only shows a product after LATENCY stable cycles.
module tb_ysyx_22040632_mulctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  op        [2];
  logic [1:0]  word;
  logic [63:0] src1      [2];
  logic [63:0] src2      [2];
  logic [4:0]  tag_in    [2];
  logic [1:0]  flush;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [63:0] out_result[2];
  logic [4:0]  out_tag   [2];
  logic [63:0] mcand_mon [2];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int L = (g == 0) ? 3 : 1;

    ysyx_22040632_mulif mif ();

    ysyx_22040632_mulctl #(.LATENCY(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op        (op[g]),
      .word      (word[g]),
      .src1      (src1[g]),
      .src2      (src2[g]),
      .tag_in    (tag_in[g]),
      .flush     (flush[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_result(out_result[g]),
      .out_tag   (out_tag[g]),
      .mul       (mif)
    );

    assign mcand_mon[g] = mif.multiplicand;

    logic [127:0] ea, eb, prod;
    logic [127:0] pipe [8];

    always_comb begin
      ea = '0;
      eb = '0;
      if (mif.mulw) begin
        ea = {{96{mif.multiplicand[31]}}, mif.multiplicand[31:0]};
        eb = {{96{mif.multiplier[31]}}, mif.multiplier[31:0]};
      end else begin
        ea = {{64{mif.mul_signed[1] & mif.multiplicand[63]}}, mif.multiplicand};
        eb = {{64{mif.mul_signed[0] & mif.multiplier[63]}}, mif.multiplier};
      end
      prod = ea * eb;
    end

    always_ff @(posedge clk) begin
      pipe[0] <= prod;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 1) begin : g_comb
      assign {mif.result_hi, mif.result_lo} = prod;
    end else begin : g_pipe
      assign {mif.result_hi, mif.result_lo} = pipe[L-2];
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Issues one request, measures accept-to-valid latency, optionally stalls the consumer, then handshakes.
  task automatic applyStimulus(input int d, input logic [1:0] o, input logic w,
                               input logic [63:0] s1, input logic [63:0] s2, input logic [4:0] t,
                               input int lat, input logic [63:0] exp, input bit hold);
    int cycles;
    @(negedge clk);
    checkOutput("in_ready_idle", {63'd0, in_ready[d]}, 64'd1);
    op[d] = o; word[d] = w; src1[d] = s1; src2[d] = s2; tag_in[d] = t;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    src1[d] = ~s1; src2[d] = ~s2; tag_in[d] = ~t;
    cycles = 0;
    checkOutput("in_ready_busy", {63'd0, in_ready[d]}, 64'd0);
    checkOutput("operand_held", mcand_mon[d], s1);
    while (!out_valid[d] && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'(lat));
    checkOutput("result", out_result[d], exp);
    checkOutput("tag", {59'd0, out_tag[d]}, {59'd0, t});
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checkOutput("hold_valid", {63'd0, out_valid[d]}, 64'd1);
        checkOutput("hold_result", out_result[d], exp);
        checkOutput("hold_in_ready", {63'd0, in_ready[d]}, 64'd0);
      end
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    checkOutput("post_hs_valid", {63'd0, out_valid[d]}, 64'd0);
    checkOutput("post_hs_in_ready", {63'd0, in_ready[d]}, 64'd1);
    checkOutput("idle_operand_kept", mcand_mon[d], s1);
  endtask

  task automatic resetMidWait(input int d, input int lat);
    bit seen;
    @(negedge clk);
    op[d] = 2'b00; word[d] = 1'b0; src1[d] = 64'd6; src2[d] = 64'd7; tag_in[d] = 5'd3;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    rst_n[d] = 1'b0;
    @(negedge clk);
    rst_n[d] = 1'b1;
    checkOutput("rst_out_valid", {63'd0, out_valid[d]}, 64'd0);
    checkOutput("rst_out_result", out_result[d], 64'd0);
    checkOutput("rst_out_tag", {59'd0, out_tag[d]}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready[d]}, 64'd1);
    checkOutput("rst_operand", mcand_mon[d], 64'd0);
    seen = 1'b0;
    for (int i = 0; i < lat + 4; i++) begin
      @(negedge clk);
      if (out_valid[d]) seen = 1'b1;
    end
    checkOutput("rst_no_valid", {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    rst_n = 2'b00; in_valid = 2'b00; word = 2'b00; flush = 2'b00; out_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      op[d] = 2'b00; src1[d] = '0; src2[d] = '0; tag_in[d] = '0;
    end

    vecs[0] = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'h1};
    vecs[1] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'h0};
    vecs[2] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{2'b00, 1'b0, 64'd3, 64'd5, 5'd4, 64'hF};
    vecs[4] = '{2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{2'b01, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[6] = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd31, 64'hFFFF_FFFF_FFFF_FFF1};

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", {63'd0, out_valid[0]}, 64'd0);
    checkOutput("reset_out_result", out_result[0], 64'd0);
    checkOutput("reset_out_tag", {59'd0, out_tag[0]}, 64'd0);
    checkOutput("reset_operand", mcand_mon[0], 64'd0);
    rst_n = 2'b11;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {63'd0, in_ready[0]}, 64'd1);
    checkOutput("in_ready_after_reset_l1", {63'd0, in_ready[1]}, 64'd1);

    $display("[TB] table vectors, LATENCY=3");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, vecs[i].op, vecs[i].word, vecs[i].s1, vecs[i].s2, vecs[i].tag, 3, vecs[i].exp, 1'b0);
    end

    $display("[TB] consumer stall");
    applyStimulus(0, 2'b00, 1'b0, 64'd9, 64'd9, 5'd12, 3, 64'd81, 1'b1);

    $display("[TB] flush after accept");
    @(negedge clk);
    op[0] = 2'b00; word[0] = 1'b0; src1[0] = 64'd10; src2[0] = 64'd10; tag_in[0] = 5'd8;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    checkOutput("flush_in_ready", {63'd0, in_ready[0]}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid[0]) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush_no_valid", {63'd0, seen}, 64'd0);
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    checkOutput("flush_blocks_accept", {63'd0, in_ready[0]}, 64'd1);
    applyStimulus(0, 2'b00, 1'b0, 64'd2, 64'd2, 5'd9, 3, 64'd4, 1'b0);

    $display("[TB] reset mid-wait");
    resetMidWait(0, 3);
    resetMidWait(1, 1);

    $display("[TB] LATENCY=1");
    applyStimulus(1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 1, 64'h1, 1'b0);
    applyStimulus(1, 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd11, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
